// File: rtl/id_stage_pipe_pkg.sv
// Shared decode encodings and the ID/EXE control bundle for the decode stage.
// Used by controller, id_stage_pipe and the bench.
package id_pkg;

  typedef enum logic [3:0] {
    EXE_ADD = 4'd0,
    EXE_SUB = 4'd2,
    EXE_AND = 4'd4,
    EXE_OR  = 4'd5,
    EXE_NOR = 4'd6,
    EXE_XOR = 4'd7,
    EXE_SHL = 4'd8,
    EXE_SRA = 4'd9,
    EXE_SRL = 4'd10
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam int unsigned REG_ZERO = 0;

  // Control half of the ID/EXE register; the datapath fields are DATA_W-sized in the stage.
  typedef struct packed {
    exe_cmd_e cmd;
    br_type_e br_type;
    logic     mem_r;
    logic     mem_w;
    logic     wb_en;
    logic     single_src;
    logic     is_bne;
  } id_ex_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID, write-back and ID/EXE signal bundle of the decode stage.
// master drives instructions/write-back and observes the ID/EXE outputs; slave is the stage.
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);
  logic              if_valid;
  logic [31:0]       instr;
  logic              id_ready;
  logic              ex_stall;
  logic              flush;
  logic              wb_en;
  logic [RA_W-1:0]   wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [RA_W-1:0]   ex_dest;
  logic [DATA_W-1:0] ex_val1;
  logic [DATA_W-1:0] ex_val2;
  logic [DATA_W-1:0] ex_reg2;
  logic [RA_W-1:0]   ex_src1;
  logic [RA_W-1:0]   ex_src2;
  logic [3:0]        ex_cmd;
  logic [1:0]        ex_br_type;
  logic              ex_mem_r;
  logic              ex_mem_w;
  logic              ex_wb_en;
  logic              ex_single_src;
  logic              ex_is_bne;
  logic              hazard;

  modport master (
    output if_valid, instr, ex_stall, flush, wb_en, wb_dest, wb_data,
    input  id_ready, ex_valid, ex_dest, ex_val1, ex_val2, ex_reg2, ex_src1, ex_src2,
           ex_cmd, ex_br_type, ex_mem_r, ex_mem_w, ex_wb_en, ex_single_src, ex_is_bne, hazard
  );

  modport slave (
    input  if_valid, instr, ex_stall, flush, wb_en, wb_dest, wb_data,
    output id_ready, ex_valid, ex_dest, ex_val1, ex_val2, ex_reg2, ex_src1, ex_src2,
           ex_cmd, ex_br_type, ex_mem_r, ex_mem_w, ex_wb_en, ex_single_src, ex_is_bne, hazard
  );
endinterface

// File: rtl/controller.sv
// Combinational opcode decode into EXE command, branch type and enables.
// Zero latency, no state.
module controller
  import id_pkg::*;
(
  input  logic [5:0] opcode_i,
  output exe_cmd_e   exe_cmd_o,
  output br_type_e   br_type_o,
  output logic       mem_r_o,
  output logic       mem_w_o,
  output logic       wb_en_o,
  output logic       is_imm_o,
  output logic       single_src_o,
  output logic       is_bne_o
);

  always_comb begin
    exe_cmd_o    = EXE_ADD;
    br_type_o    = BR_NONE;
    mem_r_o      = 1'b0;
    mem_w_o      = 1'b0;
    wb_en_o      = 1'b0;
    is_imm_o     = 1'b0;
    single_src_o = 1'b0;
    is_bne_o     = 1'b0;
    case (opcode_i)
      OP_ADD:  begin exe_cmd_o = EXE_ADD; wb_en_o = 1'b1; end
      OP_SUB:  begin exe_cmd_o = EXE_SUB; wb_en_o = 1'b1; end
      OP_AND:  begin exe_cmd_o = EXE_AND; wb_en_o = 1'b1; end
      OP_OR:   begin exe_cmd_o = EXE_OR;  wb_en_o = 1'b1; end
      OP_NOR:  begin exe_cmd_o = EXE_NOR; wb_en_o = 1'b1; end
      OP_XOR:  begin exe_cmd_o = EXE_XOR; wb_en_o = 1'b1; end
      OP_SLA,
      OP_SLL:  begin exe_cmd_o = EXE_SHL; wb_en_o = 1'b1; end
      OP_SRA:  begin exe_cmd_o = EXE_SRA; wb_en_o = 1'b1; end
      OP_SRL:  begin exe_cmd_o = EXE_SRL; wb_en_o = 1'b1; end
      OP_ADDI: begin exe_cmd_o = EXE_ADD; wb_en_o = 1'b1; is_imm_o = 1'b1; single_src_o = 1'b1; end
      OP_SUBI: begin exe_cmd_o = EXE_SUB; wb_en_o = 1'b1; is_imm_o = 1'b1; single_src_o = 1'b1; end
      OP_LD:   begin mem_r_o = 1'b1; wb_en_o = 1'b1; is_imm_o = 1'b1; single_src_o = 1'b1; end
      // Stores need rt as data, so they are not single-source.
      OP_ST:   begin mem_w_o = 1'b1; is_imm_o = 1'b1; end
      OP_BEZ:  begin br_type_o = BR_BEZ; is_imm_o = 1'b1; single_src_o = 1'b1; end
      OP_BNE:  begin br_type_o = BR_BNE; is_imm_o = 1'b1; is_bne_o = 1'b1; end
      OP_JMP:  begin br_type_o = BR_JMP; is_imm_o = 1'b1; single_src_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe_reg_file_bypass.sv
// Register file, two combinational read ports, one write port; r0 is hard zero.
// ID_BYPASS_EN: reads of the register being written this cycle return wb data.
module reg_file_bypass #(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 32,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra1_i,
  input  logic [RA_W-1:0]   ra2_i,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);
  import id_pkg::*;

  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic              wr_ok;

  assign wr_ok = we_i && (wa_i != RA_W'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = (ra1_i == RA_W'(REG_ZERO)) ? '0 : mem_q[ra1_i];
    rd2_o = (ra2_i == RA_W'(REG_ZERO)) ? '0 : mem_q[ra2_i];
`ifdef ID_BYPASS_EN
    if (wr_ok && (ra1_i == wa_i)) rd1_o = wd_i;
    if (wr_ok && (ra2_i == wa_i)) rd2_o = wd_i;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with registered ID/EXE output (1 cycle); stalls IF on load-use or ex_stall.
// Optional same-cycle write-back bypass in the register file under ID_BYPASS_EN.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int REG_CNT = 32,
  localparam int RA_W    = $clog2(REG_CNT)
) (
  input logic         clk,
  input logic         rst,
  id_stage_pipe_if.slave bus
);

  logic [RA_W-1:0]   rs, rt, rd, dest;
  logic [DATA_W-1:0] rd1, rd2, imm_ext, val2;
  exe_cmd_e          dec_cmd;
  br_type_e          dec_br;
  logic              dec_mem_r, dec_mem_w, dec_wb_en, dec_imm, dec_ss, dec_bne;
  id_ex_t            dec_ctrl;
  logic              hazard;

  logic              ex_valid_q, ex_valid_d;
  id_ex_t            ctrl_q, ctrl_d;
  logic [RA_W-1:0]   dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d, reg2_q, reg2_d;

  assign rs      = bus.instr[21 +: RA_W];
  assign rt      = bus.instr[16 +: RA_W];
  assign rd      = bus.instr[11 +: RA_W];
  assign imm_ext = DATA_W'($signed(bus.instr[15:0]));

  controller u_ctrl (
    .opcode_i     (bus.instr[31:26]),
    .exe_cmd_o    (dec_cmd),
    .br_type_o    (dec_br),
    .mem_r_o      (dec_mem_r),
    .mem_w_o      (dec_mem_w),
    .wb_en_o      (dec_wb_en),
    .is_imm_o     (dec_imm),
    .single_src_o (dec_ss),
    .is_bne_o     (dec_bne)
  );

  reg_file_bypass #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .we_i  (bus.wb_en),
    .wa_i  (bus.wb_dest),
    .wd_i  (bus.wb_data),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign dest     = dec_imm ? rt : rd;
  assign val2     = dec_imm ? imm_ext : rd2;
  assign dec_ctrl = '{cmd: dec_cmd, br_type: dec_br, mem_r: dec_mem_r, mem_w: dec_mem_w,
                      wb_en: dec_wb_en, single_src: dec_ss, is_bne: dec_bne};

  // Only a load in ID/EXE can't be forwarded in time; single-source ops don't read rt.
  assign hazard = bus.if_valid && ex_valid_q && ctrl_q.mem_r &&
                  (dest_q != RA_W'(REG_ZERO)) &&
                  ((rs == dest_q) || (!dec_ss && (rt == dest_q)));

  always_comb begin
    ex_valid_d = ex_valid_q;
    ctrl_d     = ctrl_q;
    dest_d     = dest_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    val1_d     = val1_q;
    val2_d     = val2_q;
    reg2_d     = reg2_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
    end else if (bus.ex_stall) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      ctrl_d     = '0;
    end else begin
      ex_valid_d = bus.if_valid;
      ctrl_d     = bus.if_valid ? dec_ctrl : '0;
      dest_d     = dest;
      src1_d     = rs;
      src2_d     = rt;
      val1_d     = rd1;
      val2_d     = val2;
      reg2_d     = rd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= '0;
      dest_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      reg2_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ctrl_q     <= ctrl_d;
      dest_q     <= dest_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      reg2_q     <= reg2_d;
    end
  end

  assign bus.id_ready      = !hazard && !bus.ex_stall;
  assign bus.hazard        = hazard;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_dest       = dest_q;
  assign bus.ex_val1       = val1_q;
  assign bus.ex_val2       = val2_q;
  assign bus.ex_reg2       = reg2_q;
  assign bus.ex_src1       = src1_q;
  assign bus.ex_src2       = src2_q;
  assign bus.ex_cmd        = ctrl_q.cmd;
  assign bus.ex_br_type    = ctrl_q.br_type;
  assign bus.ex_mem_r      = ctrl_q.mem_r;
  assign bus.ex_mem_w      = ctrl_q.mem_w;
  assign bus.ex_wb_en      = ctrl_q.wb_en;
  assign bus.ex_single_src = ctrl_q.single_src;
  assign bus.ex_is_bne     = ctrl_q.is_bne;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a scoreboard of expected ID/EXE contents.
module tb_id_stage_pipe;
  import id_pkg::*;

`ifdef ID_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] v1, v2, r2;
    logic [4:0]  s1, s2;
    logic [3:0]  cmd;
    logic [1:0]  br;
    logic        mr, mw, wb, ss, bne;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(32), .RA_W(5)) bus ();
  id_stage_pipe #(.DATA_W(32), .REG_CNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic push(input logic [4:0] dest, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] r2, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [3:0] cmd, input logic [1:0] br, input logic mr, input logic mw,
                      input logic wb, input logic ss, input logic bne);
    exp_t e;
    e.dest = dest; e.v1 = v1; e.v2 = v2; e.r2 = r2; e.s1 = s1; e.s2 = s2;
    e.cmd = cmd; e.br = br; e.mr = mr; e.mw = mw; e.wb = wb; e.ss = ss; e.bne = bne;
    sb.push_back(e);
  endtask

  task automatic drv(input logic vld, input logic [31:0] ins, input logic stall, input logic fl,
                     input logic we, input logic [4:0] wd, input logic [31:0] wdat);
    bus.if_valid = vld;  bus.instr   = ins;  bus.ex_stall = stall; bus.flush = fl;
    bus.wb_en    = we;   bus.wb_dest = wd;   bus.wb_data  = wdat;
  endtask

  task automatic cmp_fields(input exp_t e);
    chk("ex_dest", bus.ex_dest, e.dest);
    chk("ex_val1", bus.ex_val1, e.v1);
    chk("ex_val2", bus.ex_val2, e.v2);
    chk("ex_reg2", bus.ex_reg2, e.r2);
    chk("ex_src1", bus.ex_src1, e.s1);
    chk("ex_src2", bus.ex_src2, e.s2);
    chk("ex_cmd", bus.ex_cmd, e.cmd);
    chk("ex_br_type", bus.ex_br_type, e.br);
    chk("ex_mem_r", bus.ex_mem_r, e.mr);
    chk("ex_mem_w", bus.ex_mem_w, e.mw);
    chk("ex_wb_en", bus.ex_wb_en, e.wb);
    chk("ex_single_src", bus.ex_single_src, e.ss);
    chk("ex_is_bne", bus.ex_is_bne, e.bne);
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk({tag, "_cmd"}, bus.ex_cmd, 4'd0);
    chk({tag, "_br"}, bus.ex_br_type, 2'd0);
    chk({tag, "_mem_r"}, bus.ex_mem_r, 1'b0);
    chk({tag, "_mem_w"}, bus.ex_mem_w, 1'b0);
    chk({tag, "_wb_en"}, bus.ex_wb_en, 1'b0);
  endtask

  // One clock: check hazard/id_ready before the edge, ID/EXE contents after it.
  task automatic cyc(input logic exp_hz, input logic exp_vld, input logic hold);
    #1;
    chk("hazard", bus.hazard, exp_hz);
    chk("id_ready", bus.id_ready, !exp_hz && !bus.ex_stall);
    @(posedge clk);
    #1;
    chk("ex_valid", bus.ex_valid, exp_vld);
    if (exp_vld) begin
      if (!hold) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL scoreboard_underflow observed=empty expected=entry");
        end
        if (sb.size() != 0) last = sb.pop_front();
      end
      cmp_fields(last);
    end else begin
      chk_ctrl_zero("bubble");
    end
  endtask

  initial begin
    drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_hazard", bus.hazard, 1'b0);
    chk("rst_val1", bus.ex_val1, 32'd0);
    chk_ctrl_zero("rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_id_ready", bus.id_ready, 1'b1);

    // Write r5 while the same instruction reads it.
    drv(1'b1, enc_r(OP_ADD, 5'd5, 5'd0, 5'd6), 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    push(5'd6, BYP ? 32'hDEADBEEF : 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    drv(1'b1, enc_r(OP_ADD, 5'd5, 5'd0, 5'd6), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd6, 32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 5'd0, EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);

    // LD r3 (while writing r4=0x11), then dependent ADD: one bubble.
    drv(1'b1, enc_i(OP_LD, 5'd5, 5'd3, 16'd4), 1'b0, 1'b0, 1'b1, 5'd4, 32'h11);
    push(5'd3, 32'hDEADBEEF, 32'd4, 32'd0, 5'd5, 5'd3, EXE_ADD, BR_NONE, 1, 0, 1, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    drv(1'b1, enc_r(OP_ADD, 5'd3, 5'd4, 5'd7), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    push(5'd7, 32'd0, 32'h11, 32'h11, 5'd3, 5'd4, EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);

    // LD r3 then ADDI rt=3 rs=4: single-source, no hazard.
    drv(1'b1, enc_i(OP_LD, 5'd5, 5'd3, 16'd4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd3, 32'hDEADBEEF, 32'd4, 32'd0, 5'd5, 5'd3, EXE_ADD, BR_NONE, 1, 0, 1, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    drv(1'b1, enc_i(OP_ADDI, 5'd4, 5'd3, 16'hFFFF), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd3, 32'h11, 32'hFFFFFFFF, 32'd0, 5'd4, 5'd3, EXE_ADD, BR_NONE, 0, 0, 1, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);

    // Stall holds; flush with stall kills.
    drv(1'b1, enc_r(OP_SUB, 5'd1, 5'd2, 5'd9), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    drv(1'b1, enc_i(OP_ST, 5'd4, 5'd5, 16'd8), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("flush_single_src", bus.ex_single_src, 1'b0);
    chk("flush_is_bne", bus.ex_is_bne, 1'b0);

    // Write to r0 is dropped and never bypassed.
    drv(1'b1, enc_r(OP_ADD, 5'd0, 5'd0, 5'd8), 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
    push(5'd8, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    drv(1'b1, enc_r(OP_ADD, 5'd0, 5'd0, 5'd8), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd8, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);

    drv(1'b1, enc_i(OP_ST, 5'd4, 5'd5, 16'd8), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd5, 32'h11, 32'd8, 32'hDEADBEEF, 5'd4, 5'd5, EXE_ADD, BR_NONE, 0, 1, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    drv(1'b1, enc_i(OP_BNE, 5'd4, 5'd3, 16'h0010), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd3, 32'h11, 32'h10, 32'd0, 5'd4, 5'd3, EXE_ADD, BR_BNE, 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 1'b0);
    drv(1'b0, enc_r(OP_ADD, 5'd5, 5'd4, 5'd9), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    drv(1'b1, enc_r(OP_SUB, 5'd5, 5'd4, 5'd9), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd9, 32'hDEADBEEF, 32'h11, 32'h11, 5'd5, 5'd4, EXE_SUB, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, sampled before the next edge.
    rst = 1'b1;
    #1;
    chk("arst_ex_valid", bus.ex_valid, 1'b0);
    chk("arst_dest", bus.ex_dest, 5'd0);
    chk("arst_val1", bus.ex_val1, 32'd0);
    chk("arst_val2", bus.ex_val2, 32'd0);
    chk("arst_reg2", bus.ex_reg2, 32'd0);
    chk("arst_src1", bus.ex_src1, 5'd0);
    chk_ctrl_zero("arst");
    rst = 1'b0;
    drv(1'b1, enc_r(OP_ADD, 5'd5, 5'd4, 5'd10), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    push(5'd10, 32'd0, 32'd0, 32'd0, 5'd5, 5'd4, EXE_ADD, BR_NONE, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
